// File: rtl/array_logger_pkg.sv
// Shared types and default widths for the array write logger.
//   log_event_t : {addr, old_val, new_val} change record at default widths
//   fsm_state_e : occupancy tracking states of the event FIFO
package array_logger_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned ADDR_W_DEF     = 2;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF      = 8;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] old_val;
    logic [DATA_W_DEF-1:0] new_val;
  } log_event_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/event_fifo.sv
// Circular event FIFO with drop accounting.
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_push, i_data       push request and entry
//   o_valid, i_ready     head handshake (pop = o_valid && i_ready)
//   o_data               head entry, stable until popped
//   o_overflow           sticky: a push was dropped
//   o_drop_cnt           saturating count of dropped pushes
module event_fifo
  import array_logger_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_data,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_drop_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;
  fsm_state_e       r_state, w_state_nxt;

  logic             w_empty, w_full, w_pop, w_push_acc, w_drop;
  logic [PTR_W-1:0] w_count, w_count_nxt;

  // Flags come straight from the tracking FSM state
  assign w_empty    = (r_state == ST_IDLE);
  assign w_full     = (r_state == ST_FULL);
  assign w_pop      = !w_empty && i_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push_acc = i_push && (!w_full || w_pop);
  assign w_drop     = i_push && w_full && !w_pop;

  assign w_count     = r_wptr - r_rptr;
  assign w_count_nxt = w_count + PTR_W'(w_push_acc) - PTR_W'(w_pop);

  // Tracking FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Tracking FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_push_acc) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        if (w_count_nxt == PTR_W'(DEPTH)) w_state_nxt = ST_FULL;
        else if (w_count_nxt == '0)       w_state_nxt = ST_IDLE;
      end
      ST_FULL:   if (w_pop && !i_push) w_state_nxt = ST_ACTIVE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Storage, pointers and drop accounting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push_acc) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign o_valid    = !w_empty;
  assign o_data     = r_mem[r_rptr[AW-1:0]];
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/array_write_logger.sv
// Small register array with a registered read port that logs every
// value-changing write as an {addr, old, new} event into a FIFO.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_wr_en, i_wr_addr, i_wr_data  array write
//   i_rd_en, i_rd_addr             read request (latency 1)
//   o_rd_data, o_rd_valid          read result
//   o_ev_valid, i_ev_ready         event handshake
//   o_ev_addr, o_ev_old, o_ev_new  head event fields
//   o_overflow, o_drop_cnt         dropped-event status
module array_write_logger
  import array_logger_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_ev_valid,
  input  logic              i_ev_ready,
  output logic [ADDR_W-1:0] o_ev_addr,
  output logic [DATA_W-1:0] o_ev_old,
  output logic [DATA_W-1:0] o_ev_new,
  output logic              o_overflow,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  localparam int unsigned ARR_DEPTH = 2 ** ADDR_W;
  localparam int unsigned EV_W      = ADDR_W + 2 * DATA_W;

  logic [DATA_W-1:0] r_arr [ARR_DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic [DATA_W-1:0] w_old;
  logic              w_push;
  logic [EV_W-1:0]   w_push_ev, w_head_ev;

  // Change detection against the pre-edge stored value
  assign w_old     = r_arr[i_wr_addr];
  assign w_push    = i_wr_en && (i_wr_data != w_old);
  assign w_push_ev = {i_wr_addr, w_old, i_wr_data};

  // Array storage; writes of an identical value are harmless
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(ARR_DEPTH); i++) r_arr[i] <= '0;
    end else if (i_wr_en) begin
      r_arr[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; sees the pre-write value on a same-address write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) r_rd_data <= r_arr[i_rd_addr];
    end
  end

  event_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_data     (w_push_ev),
    .o_valid    (o_ev_valid),
    .i_ready    (i_ev_ready),
    .o_data     (w_head_ev),
    .o_overflow (o_overflow),
    .o_drop_cnt (o_drop_cnt)
  );

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_ev_addr  = w_head_ev[EV_W-1 -: ADDR_W];
  assign o_ev_old   = w_head_ev[2*DATA_W-1 -: DATA_W];
  assign o_ev_new   = w_head_ev[DATA_W-1:0];

endmodule

// File: doc/array_write_logger.md
Name: array_write_logger

Overview:
- Storage plus observation stage that sits directly downstream of the sequencing FSM that writes test arrays.
- Holds a small register array written by the FSM and provides a registered read port.
- On every write that changes a stored value, it queues a change event {addr, old, new} in a small FIFO.
- A downstream consumer, such as a bench printer or scoreboard, drains the FIFO over a valid/ready handshake. This replaces simulation-only $monitor behaviour with synthesizable, checkable hardware.

Parameters:
- DATA_W, 32, array word width.
- ADDR_W, 2, array address width; array depth is 2**ADDR_W.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2 and ≥2.
- CNT_W, 8, width of the dropped-event counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  array write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data, registered.
- rd_valid  out  1  rd_data valid for exactly one cycle.
- ev_valid  out  1  event available at the FIFO head.
- ev_ready  in  1  consumer accepts the event.
- ev_addr  out  ADDR_W  event address.
- ev_old  out  DATA_W  value before the write.
- ev_new  out  DATA_W  value after the write.
- overflow  out  1  sticky; set when an event was dropped.
- drop_cnt  out  CNT_W  number of dropped events; saturates at all-ones.

Behaviour:

Reset (reset=0, asynchronous):
- All array words clear to 0.
- FIFO is empty.
- Outputs: rd_data=0, rd_valid=0, ev_valid=0, ev_addr/ev_old/ev_new=0, overflow=0, drop_cnt=0.
- Reset asserted mid-operation discards all queued events and stored data immediately.

Array write:
- When wr_en=1 at a rising edge, array[wr_addr] <= wr_data.
- Change detection: if wr_data != array[wr_addr] (the pre-edge value), a push request forms {wr_addr, array[wr_addr], wr_data}.
- A write of an identical value updates nothing and queues no event.

Read:
- rd_en at edge N gives rd_data/rd_valid at edge N+1 (latency 1).
- Read and write to the same address in the same cycle: rd_data returns the OLD value (read-before-write).
- When rd_en=0, rd_valid=0 and rd_data holds its last value.

Event FIFO:
- Circular buffer using read/write pointers of width log2(FIFO_DEPTH)+1; the extra MSB distinguishes full from empty.
- ev_valid = !empty. The ev_* outputs show the head entry and stay stable while ev_valid && !ev_ready.
- pop = ev_valid && ev_ready.
- push = change detected.
- Event latency: a write at edge N makes ev_valid visible after edge N (first entry available the cycle after the write).
- Push with the FIFO not full: accepted.
- Push with the FIFO full and pop in the same cycle: accepted; occupancy is unchanged.
- Push with the FIFO full and no pop: the event is dropped, overflow <= 1, drop_cnt increments and saturates. Array contents still update.
- Pop when empty: impossible because ev_valid=0; ev_ready is ignored.
- Pointer wrap: pointers wrap modulo 2*FIFO_DEPTH with no special handling.
- overflow and drop_cnt clear only on reset.

Control FSM (write-path tracking, one-hot or encoded):
- IDLE -> ACTIVE on the first event pushed.
- ACTIVE -> FULL when occupancy reaches FIFO_DEPTH.
- FULL -> ACTIVE on a pop without a push.
- ACTIVE -> IDLE when the FIFO drains to empty.
- The FSM drives the internal full/empty flags; it has no output beyond those flags.

Decomposition:
- Package array_logger_pkg:
  - Event struct typedef {addr, old_val, new_val}.
  - FSM state enum {IDLE, ACTIVE, FULL}.
  - Default width constants.
- Sub-module event_fifo:
  - Parameterised by entry width and depth.
  - Contains the pointers, full/empty logic and the drop counter.
- array_write_logger instantiates event_fifo once and owns the array, the read port and change detection.

Test Plan:
- Reset check: with reset=0, then released, all outputs are 0. rd_en at address 3 returns rd_data=0 with rd_valid=1 one cycle later.
- Write addr 3 = 0x123 with ev_ready=1: next cycle ev_valid=1 with ev_addr=3, ev_old=0, ev_new=0x123. Then write addr 3 = 0xABC: event shows ev_old=0x123, ev_new=0xABC.
- Write addr 3 = 0xABC twice in a row: only one event is queued. A read of addr 3 returns 0xABC.
- Hold ev_ready=0 and do 6 distinct changing writes: the first 4 events are retained, overflow=1 and drop_cnt=2. With ev_ready=1, the 4 retained events drain in order, then ev_valid=0.
- FIFO full plus a write and ev_ready=1 in the same cycle: the event is accepted, drop_cnt is unchanged and occupancy stays at 4.
- Assert reset mid-drain with 3 events queued: ev_valid drops immediately (asynchronously). After release, array reads return 0 and overflow=0.
